// File: rtl/kmeans_input_loader_pkg.sv
// Shared parameters, state encoding and header validation helpers for the
// k-means input loader.
package kmeans_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int MAX_K  = 8;
  localparam int K_W    = 4;
  localparam int MAX_N  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_K     = 3'd1,
    LOAD      = 3'd2,
    START     = 3'd3,
    WAIT_DONE = 3'd4,
    DRAIN     = 3'd5
  } state_t;

  // N is judged on the full stream word so oversized counts cannot alias
  // onto a legal value after truncation.
  function automatic logic n_valid(input logic [DATA_W-1:0] n);
    return (n != '0) && (32'(n) <= 32'(MAX_N));
  endfunction

  function automatic logic k_valid(input logic [DATA_W-1:0] k,
                                   input logic [ADDR_W:0]   n);
    return (k != '0) && (32'(k) <= 32'(MAX_K)) && (32'(k) <= 32'(n));
  endfunction

endpackage

// File: rtl/kmeans_input_loader_if.sv
// Stream, point-memory and core-handshake signals of the input loader.
interface kmeans_input_loader_if;
  import kmeans_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W:0]   cfg_n;
  logic [K_W-1:0]    cfg_k;
  logic              start;
  logic              core_done;
  logic              busy;
  logic              err;

  // slave: the loader itself; master: the stream source / core side
  modport slave (
    input  in_valid, in_data, core_done,
    output mem_we, mem_addr, mem_wdata, cfg_n, cfg_k, start, busy, err
  );

  modport master (
    output in_valid, in_data, core_done,
    input  mem_we, mem_addr, mem_wdata, cfg_n, cfg_k, start, busy, err
  );

endinterface

// File: rtl/kmeans_input_loader.sv
// Parses the N/K header, writes N points to point memory and starts the
// clustering core; holds off the next frame until the core is done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for header word N
// GET_K     | expecting header word K
// LOAD      | writing point words to addresses 0..N-1
// START     | last write and start pulse visible, cfg valid
// WAIT_DONE | core running, stream ignored
// DRAIN     | bad header, discarding words until in_valid drops
module kmeans_input_loader
  import kmeans_pkg::*;
(
  input logic clk,
  input logic rst_n,
  kmeans_input_loader_if.slave bus
);

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W:0]   n_reg;
  logic [K_W-1:0]    k_reg;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              start_r;
  logic              err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      index       <= '0;
      n_reg       <= '0;
      k_reg       <= '0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      start_r     <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_we_r <= 1'b0;
      start_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            n_reg <= bus.in_data[ADDR_W:0];
            err_r <= 1'b0;
            if (n_valid(bus.in_data)) begin
              state <= GET_K;
            end else begin
              err_r <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        GET_K: begin
          if (!bus.in_valid) begin
            err_r <= 1'b1;
            state <= IDLE;
          end else begin
            k_reg <= bus.in_data[K_W-1:0];
            index <= '0;
            if (k_valid(bus.in_data, n_reg)) begin
              state <= LOAD;
            end else begin
              err_r <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            mem_we_r    <= 1'b1;
            mem_addr_r  <= index;
            mem_wdata_r <= bus.in_data;
            // start is raised together with the last write so both appear in START
            if ({1'b0, index} == n_reg - 1'b1) begin
              start_r <= 1'b1;
              state   <= START;
            end else begin
              index <= index + 1'b1;
            end
          end else begin
            err_r <= 1'b1;
            state <= IDLE;
          end
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.core_done) state <= IDLE;
        end
        DRAIN: begin
          if (!bus.in_valid) state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.cfg_n     = n_reg;
  assign bus.cfg_k     = k_reg;
  assign bus.start     = start_r;
  assign bus.err       = err_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_kmeans_input_loader.sv
// Self-checking bench for kmeans_input_loader: table of frames, hand-written
// corner sequences and randomized frames checked against an outcome model.
module tb_kmeans_input_loader;
  import kmeans_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  kmeans_input_loader_if bus();

  kmeans_input_loader dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;

  logic [15:0] stim_q[$];
  logic [15:0] pts_q[$];
  int          wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          start_cnt;
  bit          start_ok;
  int          start_cfg_n;
  int          start_cfg_k;
  int          exp_last;

  typedef struct {
    string name;
    int    n;
    int    k;
    int    count;
    int    mode;
    int    exp_writes;
    int    exp_start;
    bit    exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_addr_q.push_back(int'(bus.mem_addr));
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.start === 1'b1) begin
      start_cnt++;
      start_ok    = (bus.mem_we === 1'b1) && (int'(bus.mem_addr) == exp_last);
      start_cfg_n = int'(bus.cfg_n);
      start_cfg_k = int'(bus.cfg_k);
    end
  end

  // Outcome of a frame from the stream rules alone.
  function automatic void model(input int n, input int k, input int count,
                                output int w, output int s, output bit e);
    if (n < 1 || n > MAX_N) begin
      w = 0; s = 0; e = 1'b1;
    end else if (k < 1 || k > MAX_K || k > n) begin
      w = 0; s = 0; e = 1'b1;
    end else if (count >= n) begin
      w = n; s = 1; e = 1'b0;
    end else begin
      w = count; s = 0; e = 1'b1;
    end
  endfunction

  function automatic logic [15:0] point_word(input int mode, input int i);
    case (mode)
      1:       return 16'(i);
      2:       return {8'(2 * i + 1), 8'(2 * i + 2)};
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    start_cnt = 0;
    start_ok  = 1'b0;
  endtask

  task automatic drive_stim();
    foreach (stim_q[i]) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'($urandom);
  endtask

  task automatic check_writes(input string tag, input int ew);
    int bad;
    bad = 0;
    check({tag, " write_count"}, 32'(wr_addr_q.size()), 32'(ew));
    foreach (wr_addr_q[i]) begin
      if (i >= pts_q.size() || wr_addr_q[i] != i || wr_data_q[i] !== pts_q[i]) bad++;
    end
    check({tag, " write_content_errors"}, 32'(bad), 32'd0);
  endtask

  task automatic run_frame(input string tag, input int n, input int k, input int count,
                           input int mode, input int ew, input int es, input bit ee);
    logic [15:0] p;
    clear_mon();
    exp_last = n - 1;
    stim_q.delete();
    pts_q.delete();
    stim_q.push_back(16'(n));
    stim_q.push_back(16'(k));
    for (int i = 0; i < count; i++) begin
      p = point_word(mode, i);
      pts_q.push_back(p);
      stim_q.push_back(p);
    end
    drive_stim();
    repeat (3) @(negedge clk);
    check_writes(tag, ew);
    check({tag, " start_pulses"}, 32'(start_cnt), 32'(es));
    check({tag, " err"}, 32'(bus.err), 32'(ee));
    check({tag, " busy"}, 32'(bus.busy), 32'(es));
    if (es != 0) begin
      check({tag, " start_with_last_write"}, 32'(start_ok), 32'd1);
      check({tag, " cfg_n_at_start"}, 32'(start_cfg_n), 32'(n));
      check({tag, " cfg_k_at_start"}, 32'(start_cfg_k), 32'(k));
      @(posedge clk); #1;
      bus.core_done = 1'b1;
      @(posedge clk); #1;
      bus.core_done = 1'b0;
      @(negedge clk);
      check({tag, " busy_after_done"}, 32'(bus.busy), 32'd0);
      check({tag, " cfg_n_stable"}, 32'(bus.cfg_n), 32'(n));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, s;
    bit e;
    int n, k, count, sel;
    logic [15:0] mid_pts[2];

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.core_done = 1'b0;

    vecs.push_back('{"n4k2",     4,      2, 4,    2, 4,    1, 1'b0});
    vecs.push_back('{"n4096k4",  4096,   4, 4096, 1, 4096, 1, 1'b0});
    vecs.push_back('{"n0",       0,      7, 2,    0, 0,    0, 1'b1});
    vecs.push_back('{"n2k1",     2,      1, 2,    0, 2,    1, 1'b0});
    vecs.push_back('{"k_gt_n",   3,      5, 3,    0, 0,    0, 1'b1});
    vecs.push_back('{"k_gt_max", 3,      9, 3,    0, 0,    0, 1'b1});
    vecs.push_back('{"short",    8,      2, 5,    0, 5,    0, 1'b1});
    vecs.push_back('{"n4097",    4097,   2, 2,    0, 0,    0, 1'b1});
    vecs.push_back('{"n_alias",  'h2004, 2, 4,    0, 0,    0, 1'b1});
    vecs.push_back('{"k_max",    8,      8, 8,    0, 8,    1, 1'b0});
    vecs.push_back('{"k0",       5,      0, 5,    0, 0,    0, 1'b1});
    vecs.push_back('{"n1k1",     1,      1, 1,    0, 1,    1, 1'b0});
    vecs.push_back('{"extra",    3,      3, 6,    0, 3,    1, 1'b0});

    repeat (3) @(negedge clk);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset start", 32'(bus.start), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset cfg_n", 32'(bus.cfg_n), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].n, vecs[i].k, vecs[i].count, vecs[i].mode,
                vecs[i].exp_writes, vecs[i].exp_start, vecs[i].exp_err);
    end

    // header cut off after N
    clear_mon();
    pts_q.delete();
    stim_q.delete();
    stim_q.push_back(16'd5);
    drive_stim();
    repeat (3) @(negedge clk);
    check("trunc_hdr err", 32'(bus.err), 32'd1);
    check("trunc_hdr writes", 32'(wr_addr_q.size()), 32'd0);
    check("trunc_hdr start", 32'(start_cnt), 32'd0);
    check("trunc_hdr busy", 32'(bus.busy), 32'd0);

    // reset in the middle of loading 6 points
    clear_mon();
    exp_last = -1;
    mid_pts[0] = 16'hAAAA;
    mid_pts[1] = 16'h5555;
    pts_q.delete();
    pts_q.push_back(mid_pts[0]);
    pts_q.push_back(mid_pts[1]);
    stim_q.delete();
    stim_q.push_back(16'd6);
    stim_q.push_back(16'd2);
    stim_q.push_back(mid_pts[0]);
    stim_q.push_back(mid_pts[1]);
    foreach (stim_q[i]) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = stim_q[i];
    end
    @(posedge clk); #1;
    rst_n       = 1'b0;
    bus.in_data = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    check("midrst mem_we", 32'(bus.mem_we), 32'd0);
    check("midrst busy", 32'(bus.busy), 32'd0);
    check("midrst cfg_n", 32'(bus.cfg_n), 32'd0);
    check("midrst mem_wdata", 32'(bus.mem_wdata), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_writes("midrst", 2);
    check("midrst start", 32'(start_cnt), 32'd0);
    run_frame("after_rst", 3, 1, 3, 0, 3, 1, 1'b0);

    for (int r = 0; r < 25; r++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = 0;
      else if (sel == 1) n = $urandom_range(4097, 65535);
      else               n = $urandom_range(1, 24);
      k     = $urandom_range(0, 10);
      count = $urandom_range(0, 26);
      model(n, k, count, w, s, e);
      run_frame($sformatf("rand%0d", r), n, k, count, 0, w, s, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kmeans_input_loader.md
Name: kmeans_input_loader

Overview:
- Front-end stage of the k-means accelerator; sits directly upstream of the point memory and clustering core.
- Receives the serial 16-bit input stream: header word N (point count), header word K (cluster count), then N point words. Each point word is packed {x[15:8], y[7:0]}.
- Writes the points into the point SRAM at addresses 0..N-1, then hands the validated configuration to the core with a one-cycle start pulse.
- Holds off new frames until the core reports done.

Parameters:
- DATA_W, 16, stream and point word width
- ADDR_W, 12, point memory address width (max N = 2^ADDR_W = 4096)
- MAX_K, 8, largest legal cluster count
- K_W, 4, width of cfg_k

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  stream word valid; must stay high for the whole frame
- in_data  in  DATA_W  stream word
- mem_we  out  1  point memory write enable
- mem_addr  out  ADDR_W  point memory write address
- mem_wdata  out  DATA_W  point memory write data
- cfg_n  out  ADDR_W+1  latched N (1..4096)
- cfg_k  out  K_W  latched K
- start  out  1  one-cycle pulse: memory loaded, cfg valid
- core_done  in  1  core finished, loader may accept next frame
- busy  out  1  high in every state except IDLE
- err  out  1  sticky header/truncation error; cleared when the next frame's first word is accepted

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All outputs go to 0; state goes to IDLE.
  - Reset applied mid-frame aborts the frame with no further mem_we.
- States: IDLE, GET_K, LOAD, START, WAIT_DONE, DRAIN.
- IDLE:
  - On in_valid=1: capture N=in_data and clear err.
  - If N==0 or N>2^ADDR_W: set err and go to DRAIN. Otherwise go to GET_K.
- GET_K:
  - If in_valid=0: set err and go to IDLE (truncated header).
  - Else capture K=in_data. If K==0, K>MAX_K or K>N: set err and go to DRAIN. Otherwise go to LOAD with index=0.
- LOAD:
  - Each cycle with in_valid=1: register mem_we=1, mem_addr=index, mem_wdata=in_data. All three are visible the cycle after the word is sampled (latency 1). Then index++.
  - When the word with index==N-1 is accepted: go to START.
  - in_valid=0 before N words: set err, go to IDLE, no start. Memory contents are left undefined.
- START:
  - start=1 for exactly one cycle. This is the same cycle the last mem_we is high.
  - cfg_n and cfg_k are stable from this cycle until the next frame's header is accepted.
  - in_valid in this state is ignored.
  - Next state: WAIT_DONE.
- WAIT_DONE:
  - in_valid is ignored (no write, no err).
  - core_done=1 → IDLE.
  - core_done high in any other state is ignored.
- DRAIN:
  - Discard words while in_valid=1.
  - First cycle with in_valid=0 → IDLE. That cycle's word is not treated as a header.
- Width rules:
  - cfg_n is ADDR_W+1 bits so that N=4096 is representable.
  - Comparison N>2^ADDR_W uses the full 16-bit in_data.
  - index is ADDR_W bits and never wraps, because LOAD exits at N-1.
- Back-to-back frames: a new header is accepted on the first IDLE cycle after WAIT_DONE exits. The minimum gap is therefore one idle cycle after core_done.
- mem_we is never high outside the cycle following a LOAD acceptance.

Decomposition:
- Shared package kmeans_pkg holds:
  - DATA_W, ADDR_W, MAX_K, K_W
  - the state enum encoding
  - helper localparam MAX_N = 1<<ADDR_W
- Sub-modules: none required. The header validation comparator may be a small function in the package. The FSM, index counter and write register stay in one module.

Test Plan:
- N=4, K=2, points 0x0102, 0x0304, 0x0506, 0x0708 contiguous:
  - mem_we high 4 cycles, addr 0..3 with matching wdata.
  - start pulses with the 4th write; cfg_n=4, cfg_k=2; busy until core_done.
- N=4096, K=4, points = index value:
  - 4096 writes, last at addr 4095 with wdata 0x0FFF.
  - cfg_n=4096, single start pulse, no err.
- Header N=0, then 3 words, then in_valid low:
  - err=1, no mem_we, no start.
  - Next valid frame (N=2, K=1) clears err and completes normally.
- N=3, K=5 (K>N):
  - err=1, DRAIN until in_valid drops, no writes.
  - Same with K=9 (>MAX_K): err=1.
- N=8, K=2, in_valid drops after 5 points:
  - 5 writes, err=1, no start, back to IDLE.
- Reset mid-LOAD after 2 of 6 points:
  - All outputs 0 the next cycle, no further writes.
  - A fresh frame after reset loads from addr 0.
